// File: rtl/multicycle_alu.sv
// Execute unit: single-cycle ALU ops plus iterative MUL/DIVU/REMU behind valid/ready handshakes.
// One operation in flight; the result is held in DONE until the consumer takes it.
module multicycle_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [SEL_WIDTH-1:0]  opSel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  busy
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [SHW-1:0] CNT_INIT = SHW'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SEL_WIDTH-1:0] OP_ADD  = 4'h0;
  localparam logic [SEL_WIDTH-1:0] OP_SUB  = 4'h1;
  localparam logic [SEL_WIDTH-1:0] OP_AND  = 4'h2;
  localparam logic [SEL_WIDTH-1:0] OP_OR   = 4'h3;
  localparam logic [SEL_WIDTH-1:0] OP_SLT  = 4'h4;
  localparam logic [SEL_WIDTH-1:0] OP_XOR  = 4'h5;
  localparam logic [SEL_WIDTH-1:0] OP_NOR  = 4'h6;
  localparam logic [SEL_WIDTH-1:0] OP_SLL  = 4'h7;
  localparam logic [SEL_WIDTH-1:0] OP_SRL  = 4'h8;
  localparam logic [SEL_WIDTH-1:0] OP_SGT  = 4'h9;
  localparam logic [SEL_WIDTH-1:0] OP_MUL  = 4'hA;
  localparam logic [SEL_WIDTH-1:0] OP_DIVU = 4'hB;
  localparam logic [SEL_WIDTH-1:0] OP_REMU = 4'hC;
  localparam logic [SEL_WIDTH-1:0] OP_SRA  = 4'hD;

  logic [1:0]            state;
  logic [SHW-1:0]        cnt;
  logic [SEL_WIDTH-1:0]  op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] acc;

  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  is_iter;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH:0]   div_diff;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;
  logic [DATA_WIDTH-1:0] prod_next;
  logic [DATA_WIDTH-1:0] fin_res;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_BUSY);

  assign shamt   = operand2[SHW-1:0];
  assign is_iter = (opSel == OP_MUL) || (opSel == OP_DIVU) || (opSel == OP_REMU);

  always_comb begin
    alu_res = '0;
    case (opSel)
      OP_ADD:  alu_res = operand1 + operand2;
      OP_SUB:  alu_res = operand1 - operand2;
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (operand1 < operand2)};
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_NOR:  alu_res = ~(operand1 | operand2);
      OP_SLL:  alu_res = operand1 << shamt;
      OP_SRL:  alu_res = operand1 >> shamt;
      OP_SGT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (operand1 > operand2)};
      OP_SRA:  alu_res = $unsigned($signed(operand1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Restoring divide: acc holds the partial remainder, a_q shifts dividend bits out
  // at the top while quotient bits enter at the bottom. A zero divisor naturally
  // yields all-ones quotient and the dividend as remainder.
  always_comb begin
    div_shift = {acc, a_q[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
    rem_next  = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
    quo_next  = {a_q[DATA_WIDTH-2:0], div_ge};
    prod_next = acc + (b_q[0] ? a_q : '0);
    case (op_q)
      OP_MUL:  fin_res = prod_next;
      OP_DIVU: fin_res = quo_next;
      default: fin_res = rem_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_iter) begin
              op_q  <= opSel;
              a_q   <= operand1;
              b_q   <= operand2;
              acc   <= '0;
              cnt   <= CNT_INIT;
              state <= S_BUSY;
            end else begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              state  <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (op_q == OP_MUL) begin
            acc <= prod_next;
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end else begin
            acc <= rem_next;
            a_q <= quo_next;
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result <= fin_res;
            zero   <= (fin_res == '0);
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (DATA_WIDTH=32): hand-computed vectors checked
// with immediate assertions, one linear stimulus sequence.
module tb_multicycle_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [3:0]  opSel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  multicycle_alu #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand1  (operand1),
    .operand2  (operand2),
    .opSel     (opSel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one operation for a single cycle, then scramble the operand inputs.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    opSel    = op;
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    issue(op, a, b);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check(tag, result, exp);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp == 32'd0)});
    tick();
  endtask

  task automatic iter(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int nbusy;
    issue(op, a, b);
    lat   = 1;
    nbusy = 0;
    while (!out_valid && lat < 60) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd33);
    check({tag, "_busycyc"}, nbusy, 32'd32);
    check(tag, result, exp);
    tick();
  endtask

  initial begin
    int quiet;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opSel     = 4'h0;
    operand1  = '0;
    operand2  = '0;

    // 1. reset
    tick();
    tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_in_ready_held", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

    // 2. ADD wrap-around
    out_ready = 1'b1;
    issue(4'h0, 32'hFFFF_FFFF, 32'h1);
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_result", result, 32'd0);
    check("add_zero", {31'b0, zero}, 32'd1);
    check("add_ready_low", {31'b0, in_ready}, 32'd0);
    tick();
    check("add_done_valid", {31'b0, out_valid}, 32'd0);
    check("add_ready_back", {31'b0, in_ready}, 32'd1);

    // remaining single-cycle ops
    single("sub",  4'h1, 32'd10,        32'd3,         32'd7);
    single("and",  4'h2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
    single("or",   4'h3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
    single("slt",  4'h4, 32'd5,         32'h8000_0000, 32'd1);
    single("slt0", 4'h4, 32'h8000_0000, 32'd5,         32'd0);
    single("xor",  4'h5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
    single("nor",  4'h6, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000);
    single("sll",  4'h7, 32'h1,         32'h0000_0123, 32'h8);
    single("srl",  4'h8, 32'h8000_0000, 32'd31,        32'h1);
    single("sgt",  4'h9, 32'h8000_0000, 32'd5,         32'd1);
    single("sgt0", 4'h9, 32'd5,         32'd5,         32'd0);
    single("sra+", 4'hD, 32'h7000_0000, 32'd4,         32'h0700_0000);
    single("opE",  4'hE, 32'd5,         32'd7,         32'd0);
    single("opF",  4'hF, 32'hFFFF_FFFF, 32'd1,         32'd0);

    // 3./4. iterative ops
    iter("mul",      4'hA, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    iter("mul_wrap", 4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    iter("divu",     4'hB, 32'd100,       32'd7,         32'd14);
    iter("remu",     4'hC, 32'd100,       32'd7,         32'd2);
    iter("divu_z",   4'hB, 32'd5,         32'd0,         32'hFFFF_FFFF);
    iter("remu_z",   4'hC, 32'd5,         32'd0,         32'd5);
    iter("divu_big", 4'hB, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF);

    // 5. backpressure with an SRA result pending
    out_ready = 1'b0;
    issue(4'hD, 32'h8000_0000, 32'd4);
    opSel    = 4'h0;
    operand1 = 32'd1;
    operand2 = 32'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_result", result, 32'hF800_0000);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_released", {31'b0, out_valid}, 32'd0);
    check("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    check("bp_no_new_op", result, 32'hF800_0000);

    // 6. reset in the middle of a DIVU
    issue(4'hB, 32'd1000, 32'd3);
    for (int i = 1; i < 10; i++) tick();
    check("mid_busy", {31'b0, busy}, 32'd1);
    rst      = 1'b1;
    opSel    = 4'h0;
    operand1 = 32'd1;
    operand2 = 32'd1;
    in_valid = 1'b1;
    #1;
    check("rst_forces_ready", {31'b0, in_ready}, 32'd0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_valid", {31'b0, out_valid}, 32'd0);
    check("abort_result", result, 32'd0);
    quiet = 1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) quiet = 0;
      tick();
    end
    check("abort_never_valid", quiet, 32'd1);
    single("sub_after", 4'h1, 32'd3, 32'd5, 32'hFFFF_FFFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
